// File: rtl/salu_seq.sv
// salu_seq: command sequencer and register file driving an external 8-bit combinational ALU.
// Latency: accept at edge N, ALU result captured at N+1, writeback and done pulse after N+2.
// Backpressure: cmd_ready is high only in IDLE, so one command is accepted every 3 cycles.
module salu_seq #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic          cmd_imm_en,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] operanda,
    output logic [DW-1:0] operandb,
    output logic [3:0]    mux,
    input  logic [DW-1:0] result,
    output logic          done,
    output logic [DW-1:0] done_data,
    output logic          err,
    output logic          zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] rf_q [NREG];
    logic [AW-1:0] dst_q;
    logic          illegal_q;
    logic          divzero_q;
    logic [DW-1:0] res_q;
    logic          accept;
    logic          divzero;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        // mux doubles as the latched opcode of the command in flight
        divzero   = (mux == 4'd3) && (operandb == '0);
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            operanda  <= '0;
            operandb  <= '0;
            mux       <= 4'd0;
            dst_q     <= '0;
            illegal_q <= 1'b0;
            divzero_q <= 1'b0;
            res_q     <= '0;
            done      <= 1'b0;
            done_data <= '0;
            err       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (accept) begin
                operanda  <= rf_q[cmd_srca];
                operandb  <= cmd_imm_en ? cmd_imm : rf_q[cmd_srcb];
                mux       <= cmd_op;
                dst_q     <= cmd_dst;
                illegal_q <= (cmd_op >= 4'hc);
            end
            // ALU output is undefined for these cases, so substitute fixed values
            if (state_q == EXEC) begin
                divzero_q <= divzero;
                res_q     <= illegal_q ? '0 : (divzero ? '1 : result);
            end
            if (state_q == WB) begin
                if (!illegal_q) begin
                    rf_q[dst_q] <= res_q;
                end
                done      <= 1'b1;
                done_data <= res_q;
                err       <= illegal_q | divzero_q;
                zero      <= (res_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_salu_seq.sv
// Bench for salu_seq: models the ALU it drives and checks every retired command against a reference model.
module tb_salu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic [7:0] operanda;
    logic [7:0] operandb;
    logic [3:0] mux;
    logic [7:0] result;
    logic       done;
    logic [7:0] done_data;
    logic       err;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mrf [4];
    logic [7:0] g;

    logic [7:0] bq_data [$];
    logic       bq_err  [$];
    int         k;
    int         cyc;
    int         last;
    int         ndone;
    logic       wa;
    logic [7:0] ba, bb, bd;
    logic       be;
    localparam int NB = 12;

    always #5 clk = ~clk;

    salu_seq #(.DW(8), .NREG(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .operanda(operanda), .operandb(operandb), .mux(mux), .result(result),
        .done(done), .done_data(done_data), .err(err), .zero(zero)
    );

    // Downstream ALU; undefined cases return junk so sanitisation is visible
    always_comb begin
        case (mux)
            4'h0:    result = operanda + operandb;
            4'h1:    result = operanda - operandb;
            4'h2:    result = operanda * operandb;
            4'h3:    result = (operandb == 8'd0) ? 8'h5A : operanda / operandb;
            4'h4:    result = ~operanda;
            4'h5:    result = operanda & operandb;
            4'h6:    result = operanda | operandb;
            4'h7:    result = ~(operanda & operandb);
            4'h8:    result = ~(operanda | operandb);
            4'h9:    result = operanda ^ operandb;
            4'ha:    result = operanda << 1;
            4'hb:    result = operanda >> 1;
            default: result = 8'hA5;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic reduced mod 256, plus error rules; updates the model register file
    task automatic model(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                         output logic [7:0] ea, output logic [7:0] eb,
                         output logic [7:0] ed, output logic ee);
        int a, b, r;
        a  = int'(mrf[sa]);
        b  = ie ? int'(imm) : int'(mrf[sb]);
        ee = 1'b0;
        r  = 0;
        if (op >= 4'd12) begin
            ee = 1'b1;
            r  = 0;
        end else if (op == 4'd3 && b == 0) begin
            ee = 1'b1;
            r  = 255;
        end else begin
            case (int'(op))
                0:       r = a + b;
                1:       r = a - b;
                2:       r = a * b;
                3:       r = a / b;
                4:       r = 255 - a;
                5:       r = a & b;
                6:       r = a | b;
                7:       r = 255 - (a & b);
                8:       r = 255 - (a | b);
                9:       r = a ^ b;
                10:      r = a * 2;
                11:      r = a / 2;
                default: r = 0;
            endcase
        end
        r  = r & 255;
        ea = 8'(a);
        eb = 8'(b);
        ed = 8'(r);
        if (op < 4'd12) mrf[dst] = ed;
    endtask

    task automatic rand_fields();
        cmd_op     = 4'($urandom_range(0, 15));
        cmd_dst    = 2'($urandom_range(0, 3));
        cmd_srca   = 2'($urandom_range(0, 3));
        cmd_srcb   = 2'($urandom_range(0, 3));
        cmd_imm_en = 1'($urandom_range(0, 1));
        cmd_imm    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                           output logic [7:0] got);
        logic [7:0] ea, eb, ed;
        logic       ee;
        int         n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
        cmd_imm_en = ie; cmd_imm = imm;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", cmd_ready, 1);
        model(op, dst, sa, sb, ie, imm, ea, eb, ed, ee);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rand_fields();
        chk("operanda", operanda, ea);
        chk("operandb", operandb, eb);
        chk("mux", mux, op);
        chk("ready_exec", cmd_ready, 0);
        chk("done_exec", done, 0);
        @(posedge clk); #1;
        chk("ready_wb", cmd_ready, 0);
        chk("done_wb", done, 0);
        @(posedge clk); #1;
        chk("done", done, 1);
        chk("done_data", done_data, ed);
        chk("err", err, ee);
        chk("zero", zero, (ed == 8'd0));
        chk("ready_after", cmd_ready, 1);
        got = done_data;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_dst = 2'd0; cmd_srca = 2'd0;
        cmd_srcb = 2'd0; cmd_imm_en = 1'b0; cmd_imm = 8'd0;
        for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_operanda", operanda, 0);
        chk("rst_operandb", operandb, 0);
        chk("rst_mux", mux, 0);
        chk("rst_done_data", done_data, 0);
        chk("rst_err", err, 0);
        chk("rst_zero", zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed walk through the basic operations and error cases
        run_cmd(4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, g); chk("tp_add1", g, 8'h05);
        run_cmd(4'h0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h03, g); chk("tp_add2", g, 8'h08);
        run_cmd(4'h1, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, g); chk("tp_sub", g, 8'h00);
        chk("tp_sub_zero", zero, 1);
        run_cmd(4'h2, 2'd0, 2'd1, 2'd0, 1'b1, 8'h40, g); chk("tp_mul", g, 8'h40);
        run_cmd(4'h3, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, g); chk("tp_div0", g, 8'hFF);
        chk("tp_div0_err", err, 1);
        run_cmd(4'h0, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, g); chk("tp_div0_wr", g, 8'hFF);
        run_cmd(4'h3, 2'd0, 2'd2, 2'd0, 1'b1, 8'h03, g); chk("tp_div", g, 8'h02);
        chk("tp_div_err", err, 0);
        run_cmd(4'hd, 2'd1, 2'd2, 2'd0, 1'b1, 8'h07, g); chk("tp_illegal", g, 8'h00);
        chk("tp_illegal_err", err, 1);
        chk("tp_illegal_zero", zero, 1);
        run_cmd(4'h0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, g); chk("tp_r1_kept", g, 8'h05);
        @(posedge clk); #1;
        chk("hold_done_pulse", done, 0);
        chk("hold_operanda", operanda, 8'h05);
        chk("hold_operandb", operandb, 8'h00);
        chk("hold_mux", mux, 4'h0);
        chk("hold_done_data", done_data, 8'h05);

        // Random single commands
        repeat (25) begin
            run_cmd(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255)), g);
        end

        // Back-to-back commands with cmd_valid held high
        k = 0; cyc = 0; last = 0; ndone = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        rand_fields();
        while ((k < NB || bq_data.size() > 0) && cyc < 200) begin
            wa = cmd_ready && cmd_valid;
            if (wa) begin
                model(cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm_en, cmd_imm, ba, bb, bd, be);
                bq_data.push_back(bd);
                bq_err.push_back(be);
            end
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                ndone++;
                if (bq_data.size() > 0) begin
                    chk("b2b_data", done_data, bq_data.pop_front());
                    chk("b2b_err", err, bq_err.pop_front());
                end else begin
                    chk("b2b_extra_done", 1, 0);
                end
            end
            if (wa) begin
                if (k > 0) chk("b2b_spacing", cyc - last, 3);
                last = cyc;
                k++;
                if (k == NB) cmd_valid = 1'b0;
                else rand_fields();
            end
            @(negedge clk);
        end
        chk("b2b_accepts", k, NB);
        chk("b2b_dones", ndone, NB);

        // Reset during EXEC aborts the command and clears everything
        run_cmd(4'h0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h77, g);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'h0; cmd_dst = 2'd2; cmd_srca = 2'd2; cmd_imm_en = 1'b1; cmd_imm = 8'h01;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst_mid_busy", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
        chk("rst_mid_done", done, 0);
        chk("rst_mid_operanda", operanda, 0);
        chk("rst_mid_operandb", operandb, 0);
        chk("rst_mid_mux", mux, 0);
        chk("rst_mid_done_data", done_data, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_zero", zero, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        @(posedge clk); #1;
        chk("rst_mid_no_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            run_cmd(4'h0, 2'(i), 2'(i), 2'd0, 1'b1, 8'h00, g);
            chk("rst_mid_reg", g, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
